// File: rtl/w0rm_core_pkg.sv
// Shared W0RM core encodings for the redirect sequencer.
// Used by redirect control, hazard unit and debug.
package w0rm_core_pkg;

    typedef enum logic [1:0] {
        REDIR_ST_IDLE     = 2'd0,
        REDIR_ST_FLUSH    = 2'd1,
        REDIR_ST_REDIRECT = 2'd2
    } redir_state_e;

    typedef enum logic {
        REDIR_SRC_BRANCH = 1'b0,
        REDIR_SRC_IRQ    = 1'b1
    } redir_src_e;

endpackage

// File: rtl/w0rm_core_redirect_ctrl_if.sv
// Redirect controller bus: branch/irq requests in, fetch redirect
// and pipeline control out. slave = controller, master = core side.
interface w0rm_core_redirect_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  branch_pc_valid;
    logic [ADDR_WIDTH-1:0] branch_pc;
    logic                  irq_valid;
    logic                  irq_enable;
    logic [ADDR_WIDTH-1:0] irq_vector;
    logic                  irq_ack;
    logic                  fetch_ready;
    logic                  fetch_pc_valid;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  flush_pipeline;
    logic                  stall_issue;
    logic                  busy;

    modport slave (
        input  branch_pc_valid, branch_pc,
        input  irq_valid, irq_enable, irq_vector,
        input  fetch_ready,
        output irq_ack, fetch_pc_valid, fetch_pc,
        output flush_pipeline, stall_issue, busy
    );

    modport master (
        output branch_pc_valid, branch_pc,
        output irq_valid, irq_enable, irq_vector,
        output fetch_ready,
        input  irq_ack, fetch_pc_valid, fetch_pc,
        input  flush_pipeline, stall_issue, busy
    );
endinterface

// File: rtl/w0rm_core_redirect_ctrl.sv
// PC-redirect sequencer: arbitrates branch/irq, flushes, hands PC to fetch.
// Ports: clk, reset (sync, active high), bus (redirect interface, slave).
module w0rm_core_redirect_ctrl
    import w0rm_core_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    w0rm_core_redirect_ctrl_if.slave   bus
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

    redir_state_e          state;
    redir_src_e            src;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic                  fetch_valid_q;
    logic                  flush_q;
    logic                  stall_q;
    logic                  irq_ack_q;
    logic                  irq_take;
    logic                  accept;

    // The irq source still holds irq_valid during the ack cycle;
    // masking it there keeps one interrupt from being taken twice.
    assign irq_take = bus.irq_valid & bus.irq_enable & ~irq_ack_q;
    assign accept   = bus.branch_pc_valid | irq_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= REDIR_ST_IDLE;
            src           <= REDIR_SRC_BRANCH;
            count         <= '0;
            target        <= '0;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
            irq_ack_q     <= 1'b0;
        end else begin
            irq_ack_q <= 1'b0;
            case (state)
                REDIR_ST_IDLE: begin
                    if (accept) begin
                        state   <= REDIR_ST_FLUSH;
                        count   <= CNT_INIT;
                        flush_q <= 1'b1;
                        stall_q <= 1'b1;
                        // branch has priority; a pending irq waits
                        if (bus.branch_pc_valid) begin
                            target <= bus.branch_pc;
                            src    <= REDIR_SRC_BRANCH;
                        end else begin
                            target <= bus.irq_vector;
                            src    <= REDIR_SRC_IRQ;
                        end
                    end
                end
                REDIR_ST_FLUSH: begin
                    if (count == '0) begin
                        state         <= REDIR_ST_REDIRECT;
                        flush_q       <= 1'b0;
                        fetch_valid_q <= 1'b1;
                        fetch_pc_q    <= {target[ADDR_WIDTH-1:1], 1'b0};
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                REDIR_ST_REDIRECT: begin
                    if (bus.fetch_ready) begin
                        state         <= REDIR_ST_IDLE;
                        fetch_valid_q <= 1'b0;
                        stall_q       <= 1'b0;
                        irq_ack_q     <= (src == REDIR_SRC_IRQ);
                    end
                end
                default: begin
                    state         <= REDIR_ST_IDLE;
                    fetch_valid_q <= 1'b0;
                    flush_q       <= 1'b0;
                    stall_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_ack        = irq_ack_q;
    assign bus.fetch_pc_valid = fetch_valid_q;
    assign bus.fetch_pc       = fetch_pc_q;
    assign bus.flush_pipeline = flush_q;
    assign bus.stall_issue    = stall_q;
    assign bus.busy           = stall_q;

endmodule

// File: tb/tb_w0rm_core_redirect_ctrl.sv
// Directed bench for the redirect sequencer (FLUSH_CYCLES 2, 1 and 4).
// Inputs driven 1 time unit after posedge; outputs checked there too.
module tb_w0rm_core_redirect_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    w0rm_core_redirect_ctrl_if #(.ADDR_WIDTH(32)) b2 ();
    w0rm_core_redirect_ctrl_if #(.ADDR_WIDTH(32)) b1 ();
    w0rm_core_redirect_ctrl_if #(.ADDR_WIDTH(32)) b4 ();

    w0rm_core_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2.slave));
    w0rm_core_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));
    w0rm_core_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .bus(b4.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if (b2.fetch_pc_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b exp=0", b2.fetch_pc_valid);
        end
        total++;
        if (b2.fetch_pc !== 32'h0) begin
            bad++; $display("FAIL reset_pc got=%h exp=0", b2.fetch_pc);
        end
        total++;
        if ({b2.flush_pipeline, b2.stall_issue, b2.busy, b2.irq_ack} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                {b2.flush_pipeline, b2.stall_issue, b2.busy, b2.irq_ack});
        end
    endtask

    task automatic test_branch();
        b2.fetch_ready = 1'b1;
        b2.branch_pc = 32'h100;
        b2.branch_pc_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            b2.branch_pc_valid = 1'b0;
            total++;
            if ({b2.flush_pipeline, b2.stall_issue, b2.fetch_pc_valid} !== 3'b110) begin
                bad++;
                $display("FAIL branch_flush%0d got=%b exp=110", i,
                    {b2.flush_pipeline, b2.stall_issue, b2.fetch_pc_valid});
            end
        end
        tick();
        total++;
        if (b2.fetch_pc_valid !== 1'b1 || b2.fetch_pc !== 32'h100 || b2.flush_pipeline !== 1'b0) begin
            bad++;
            $display("FAIL branch_redirect got v=%b pc=%h f=%b exp v=1 pc=100 f=0",
                b2.fetch_pc_valid, b2.fetch_pc, b2.flush_pipeline);
        end
        tick();
        total++;
        if ({b2.fetch_pc_valid, b2.stall_issue, b2.busy, b2.irq_ack} !== 4'b0) begin
            bad++;
            $display("FAIL branch_done got=%b exp=0000",
                {b2.fetch_pc_valid, b2.stall_issue, b2.busy, b2.irq_ack});
        end
        tick();
        total++;
        if (b2.irq_ack !== 1'b0 || b2.stall_issue !== 1'b0) begin
            bad++;
            $display("FAIL branch_noack got ack=%b stall=%b exp 0 0", b2.irq_ack, b2.stall_issue);
        end
    endtask

    task automatic test_simultaneous();
        b2.fetch_ready = 1'b1;
        b2.branch_pc = 32'h200;
        b2.branch_pc_valid = 1'b1;
        b2.irq_vector = 32'h40;
        b2.irq_valid = 1'b1;
        b2.irq_enable = 1'b1;
        tick();
        b2.branch_pc_valid = 1'b0;
        tick();
        tick();
        total++;
        if (b2.fetch_pc_valid !== 1'b1 || b2.fetch_pc !== 32'h200) begin
            bad++;
            $display("FAIL simul_first got v=%b pc=%h exp v=1 pc=200", b2.fetch_pc_valid, b2.fetch_pc);
        end
        tick();
        total++;
        if (b2.irq_ack !== 1'b0 || b2.fetch_pc_valid !== 1'b0) begin
            bad++;
            $display("FAIL simul_gap got ack=%b v=%b exp 0 0", b2.irq_ack, b2.fetch_pc_valid);
        end
        tick();
        total++;
        if (b2.flush_pipeline !== 1'b1) begin
            bad++; $display("FAIL simul_irq_flush got=%b exp=1", b2.flush_pipeline);
        end
        tick();
        tick();
        total++;
        if (b2.fetch_pc_valid !== 1'b1 || b2.fetch_pc !== 32'h40 || b2.irq_ack !== 1'b0) begin
            bad++;
            $display("FAIL simul_irq_redirect got v=%b pc=%h ack=%b exp v=1 pc=40 ack=0",
                b2.fetch_pc_valid, b2.fetch_pc, b2.irq_ack);
        end
        tick();
        total++;
        if (b2.irq_ack !== 1'b1 || b2.fetch_pc_valid !== 1'b0) begin
            bad++;
            $display("FAIL simul_ack got ack=%b v=%b exp 1 0", b2.irq_ack, b2.fetch_pc_valid);
        end
        tick();
        b2.irq_valid = 1'b0;
        total++;
        if ({b2.irq_ack, b2.flush_pipeline, b2.stall_issue} !== 3'b000) begin
            bad++;
            $display("FAIL simul_single_ack got=%b exp=000",
                {b2.irq_ack, b2.flush_pipeline, b2.stall_issue});
        end
        tick();
        total++;
        if (b2.stall_issue !== 1'b0) begin
            bad++; $display("FAIL simul_idle got=%b exp=0", b2.stall_issue);
        end
    endtask

    task automatic test_backpressure();
        b2.fetch_ready = 1'b0;
        b2.branch_pc = 32'h1234;
        b2.branch_pc_valid = 1'b1;
        tick();
        b2.branch_pc_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (b2.fetch_pc_valid !== 1'b1 || b2.fetch_pc !== 32'h1234) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b pc=%h exp v=1 pc=1234",
                    i, b2.fetch_pc_valid, b2.fetch_pc);
            end
        end
        b2.fetch_ready = 1'b1;
        tick();
        total++;
        if (b2.fetch_pc_valid !== 1'b0 || b2.stall_issue !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got v=%b stall=%b exp 0 0", b2.fetch_pc_valid, b2.stall_issue);
        end
        tick();
        total++;
        if (b2.fetch_pc_valid !== 1'b0) begin
            bad++; $display("FAIL bp_once got=%b exp=0", b2.fetch_pc_valid);
        end
    endtask

    task automatic test_busy_drop();
        b2.fetch_ready = 1'b1;
        b2.branch_pc = 32'h500;
        b2.branch_pc_valid = 1'b1;
        tick();
        b2.branch_pc = 32'h300;
        tick();
        b2.branch_pc_valid = 1'b0;
        tick();
        total++;
        if (b2.fetch_pc_valid !== 1'b1 || b2.fetch_pc !== 32'h500) begin
            bad++;
            $display("FAIL drop_first got v=%b pc=%h exp v=1 pc=500", b2.fetch_pc_valid, b2.fetch_pc);
        end
        tick();
        tick();
        total++;
        if ({b2.fetch_pc_valid, b2.flush_pipeline, b2.stall_issue} !== 3'b000) begin
            bad++;
            $display("FAIL drop_ignored got=%b exp=000",
                {b2.fetch_pc_valid, b2.flush_pipeline, b2.stall_issue});
        end
    endtask

    task automatic test_reset_mid();
        b2.fetch_ready = 1'b0;
        b2.irq_vector = 32'h80;
        b2.irq_enable = 1'b1;
        b2.irq_valid = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (b2.fetch_pc_valid !== 1'b1 || b2.fetch_pc !== 32'h80) begin
            bad++;
            $display("FAIL rst_pre got v=%b pc=%h exp v=1 pc=80", b2.fetch_pc_valid, b2.fetch_pc);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({b2.fetch_pc_valid, b2.flush_pipeline, b2.stall_issue, b2.busy, b2.irq_ack} !== 5'b0
            || b2.fetch_pc !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid got=%b pc=%h exp=00000 pc=0",
                {b2.fetch_pc_valid, b2.flush_pipeline, b2.stall_issue, b2.busy, b2.irq_ack},
                b2.fetch_pc);
        end
        reset = 1'b0;
        b2.irq_valid = 1'b0;
        b2.fetch_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (b2.irq_ack !== 1'b0 || b2.fetch_pc_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_noack%0d got ack=%b v=%b exp 0 0", i, b2.irq_ack, b2.fetch_pc_valid);
            end
        end
    endtask

    task automatic test_mask_align();
        b2.fetch_ready = 1'b1;
        b2.irq_enable = 1'b0;
        b2.irq_vector = 32'h60;
        b2.irq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (b2.stall_issue !== 1'b0 || b2.flush_pipeline !== 1'b0) begin
                bad++;
                $display("FAIL mask%0d got stall=%b flush=%b exp 0 0", i, b2.stall_issue, b2.flush_pipeline);
            end
        end
        b2.irq_valid = 1'b0;
        b2.branch_pc = 32'h101;
        b2.branch_pc_valid = 1'b1;
        tick();
        b2.branch_pc_valid = 1'b0;
        tick();
        tick();
        total++;
        if (b2.fetch_pc_valid !== 1'b1 || b2.fetch_pc !== 32'h100) begin
            bad++;
            $display("FAIL align got v=%b pc=%h exp v=1 pc=100", b2.fetch_pc_valid, b2.fetch_pc);
        end
        tick();
    endtask

    task automatic test_flush_len();
        int f1 = 0;
        int f4 = 0;
        int v1 = -1;
        int v4 = -1;
        logic [31:0] p1 = '0;
        logic [31:0] p4 = '0;
        b1.fetch_ready = 1'b1;
        b4.fetch_ready = 1'b1;
        b1.branch_pc = 32'h10;
        b4.branch_pc = 32'h20;
        b1.branch_pc_valid = 1'b1;
        b4.branch_pc_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            b1.branch_pc_valid = 1'b0;
            b4.branch_pc_valid = 1'b0;
            if (b1.flush_pipeline) f1++;
            if (b4.flush_pipeline) f4++;
            if (b1.fetch_pc_valid && v1 < 0) begin v1 = c; p1 = b1.fetch_pc; end
            if (b4.fetch_pc_valid && v4 < 0) begin v4 = c; p4 = b4.fetch_pc; end
        end
        total++;
        if (f1 != 1 || v1 != 2 || p1 !== 32'h10) begin
            bad++;
            $display("FAIL flush1 got flush=%0d vcyc=%0d pc=%h exp 1 2 10", f1, v1, p1);
        end
        total++;
        if (f4 != 4 || v4 != 5 || p4 !== 32'h20) begin
            bad++;
            $display("FAIL flush4 got flush=%0d vcyc=%0d pc=%h exp 4 5 20", f4, v4, p4);
        end
    endtask

    initial begin
        b2.branch_pc_valid = 1'b0; b2.branch_pc = '0;
        b2.irq_valid = 1'b0; b2.irq_enable = 1'b0; b2.irq_vector = '0;
        b2.fetch_ready = 1'b0;
        b1.branch_pc_valid = 1'b0; b1.branch_pc = '0;
        b1.irq_valid = 1'b0; b1.irq_enable = 1'b0; b1.irq_vector = '0;
        b1.fetch_ready = 1'b0;
        b4.branch_pc_valid = 1'b0; b4.branch_pc = '0;
        b4.irq_valid = 1'b0; b4.irq_enable = 1'b0; b4.irq_vector = '0;
        b4.fetch_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_branch();
        test_simultaneous();
        test_backpressure();
        test_busy_drop();
        test_reset_mid();
        test_mask_align();
        test_flush_len();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
